// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path (and the future transmit path):
//   frame width, default bit period, and the receiver FSM state encoding.
//   No ports; imported by uart_bit_timer and uart_rx_frontend.
package uart_pkg;

  // One start bit, DATA_BITS data bits LSB first, one stop bit.
  localparam int DATA_BITS = 8;

  // 100 MHz system clock at 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  // Receiver FSM state encoding.
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 3'd0;
  localparam uart_state_t ST_START = 3'd1;
  localparam uart_state_t ST_DATA  = 3'd2;
  localparam uart_state_t ST_STOP  = 3'd3;
  localparam uart_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Baud counter for the UART receiver. Counts sysclk cycles from a clear and
//   raises tick while the count equals the selected terminal value: half a bit
//   period (half_sel=1) or a full bit period (half_sel=0).
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   clear     in   force the count back to zero on the next edge
//   half_sel  in   1 = half-bit terminal count, 0 = full-bit terminal count
//   tick      out  count has reached the selected terminal value
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic half_sel,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] term;

  assign term = half_sel ? HALF_TERM : FULL_TERM;
  assign tick = (count == term);

  // The count holds at its terminal value until cleared, so it never wraps
  // by overflow; the FSM clears it on every tick it acts on.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (!tick) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
//   8N1 UART receiver: synchronises the asynchronous RX pin, recovers each byte
//   by mid-bit sampling and presents it in a one-byte holding register with a
//   valid/ack handshake, sticky overrun and a one-cycle framing-error pulse.
// Ports
//   sysclk     in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   UART_RX    in   asynchronous serial input, idle high
//   rx_data    out  last accepted byte
//   rx_valid   out  rx_data holds an unread byte
//   rx_ack     in   consumer has read rx_data (ignored while rx_valid=0)
//   overrun    out  sticky: a completed byte was dropped while rx_valid=1
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   busy       out  receiver is not idle
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  uart_state_t            state;
  uart_state_t            next_state;
  logic                   tick;
  logic                   timer_clear;
  logic                   half_sel;
  logic                   sample_bit;
  logic                   stop_good;
  logic                   stop_bad;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift;

  // Synchroniser resets to the idle (high) level so a reset never looks like
  // a start bit.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RX};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (sysclk),
    .reset    (reset),
    .clear    (timer_clear),
    .half_sel (half_sel),
    .tick     (tick)
  );

  // FSM state register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic. BREAK waits for the line to return high so a
  // held-low line cannot start a new frame.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!rxs) next_state = ST_START;
      ST_START: if (tick) next_state = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && (bit_cnt == LAST_BIT)) next_state = ST_STOP;
      ST_STOP:  if (tick) next_state = rxs ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rxs) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // FSM outputs. The timer is held clear while no bit is being timed and is
  // restarted on every tick, so each sample point is measured from the last.
  always_comb begin
    busy        = (state != ST_IDLE);
    half_sel    = (state == ST_START);
    timer_clear = (state == ST_IDLE) || (state == ST_BREAK) || tick;
    sample_bit  = (state == ST_DATA) && tick;
    stop_good   = (state == ST_STOP) && tick && rxs;
    stop_bad    = (state == ST_STOP) && tick && !rxs;
  end

  // Shift register and bit index; the index is zeroed whenever the FSM is
  // outside DATA so every frame starts at bit 0.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (state != ST_DATA) begin
      bit_cnt <= '0;
    end else if (sample_bit) begin
      shift[bit_cnt] <= rxs;
      if (bit_cnt != LAST_BIT) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Holding register. A delivery that coincides with rx_ack replaces the
  // unread byte instead of overrunning it.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (rx_ack && rx_valid) begin
        overrun <= 1'b0;
      end
      if (stop_good) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend
//   Directed bench for uart_rx_frontend with CLKS_PER_BIT=16, SYNC_STAGES=2.
//   Frames are driven on the pin at falling clock edges; outputs are sampled
//   at falling edges or 1 time unit after a rising edge.
module tb_uart_rx_frontend;

  localparam int CLKS_PER_BIT = 16;
  localparam int SYNC_STAGES  = 2;

  // 16/2 + 9*16 + 1 cycles from rxs, plus 2 synchroniser cycles from the pin.
  localparam int PIN_TO_VALID = 155;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int num_compared   = 0;
  int num_mismatched = 0;

  int  frame_err_cycles = 0;
  int  busy_rises       = 0;
  int  valid_rises      = 0;
  logic busy_q  = 1'b0;
  logic valid_q = 1'b0;

  uart_rx_frontend #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // 10-unit clock period.
  always #5 sysclk = ~sysclk;

  // Event monitor: counts frame_err high cycles, busy rising edges (one per
  // START entry) and rx_valid rising edges. Tests compare snapshots.
  always @(negedge sysclk) begin
    if (frame_err) frame_err_cycles <= frame_err_cycles + 1;
    if (busy && !busy_q) busy_rises <= busy_rises + 1;
    if (rx_valid && !valid_q) valid_rises <= valid_rises + 1;
    busy_q  <= busy;
    valid_q <= rx_valid;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame starting at the current falling edge; the line is
  // left at the stop-bit level afterwards.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CLKS_PER_BIT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      repeat (CLKS_PER_BIT) @(negedge sysclk);
    end
    uart_rx = stop_bit;
    repeat (CLKS_PER_BIT) @(negedge sysclk);
  endtask

  task automatic pulseAck();
    rx_ack = 1'b1;
    @(negedge sysclk);
    rx_ack = 1'b0;
  endtask

  // Hard stop in case something hangs a fork.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int latency;
    int fe0, br0, vr0;
    int wait_cnt;

    reset   = 1'b1;
    uart_rx = 1'b1;
    rx_ack  = 1'b0;
    repeat (4) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);

    // Reset values.
    checkOutput("reset_rx_data",   rx_data,   8'h00);
    checkOutput("reset_rx_valid",  rx_valid,  0);
    checkOutput("reset_overrun",   overrun,   0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_busy",      busy,      0);
    repeat (8) @(negedge sysclk);

    // Test 1: 0x55 with latency measured from the pin falling edge.
    fe0 = frame_err_cycles;
    latency = 0;
    fork
      applyStimulus(8'h55, 1'b1);
      begin
        for (int c = 1; c <= 300; c++) begin
          @(posedge sysclk);
          #1;
          if (rx_valid) begin
            latency = c;
            break;
          end
        end
      end
    join
    checkOutput("t1_latency",   latency,  PIN_TO_VALID);
    checkOutput("t1_rx_data",   rx_data,  8'h55);
    checkOutput("t1_frame_err", frame_err_cycles - fe0, 0);
    checkOutput("t1_overrun",   overrun,  0);
    pulseAck();
    checkOutput("t1_ack_clears_valid", rx_valid, 0);
    repeat (8) @(negedge sysclk);

    // Test 2: 4-cycle glitch is rejected at the start-bit sample.
    br0 = busy_rises;
    vr0 = valid_rises;
    uart_rx = 1'b0;
    repeat (4) @(negedge sysclk);
    uart_rx = 1'b1;
    wait_cnt = 0;
    while (busy && wait_cnt < 11) begin
      @(negedge sysclk);
      wait_cnt++;
    end
    checkOutput("t2_busy_dropped", busy, 0);
    repeat (30) @(negedge sysclk);
    checkOutput("t2_start_seen",  busy_rises - br0, 1);
    checkOutput("t2_no_valid",    valid_rises - vr0, 0);
    checkOutput("t2_rx_valid",    rx_valid, 0);

    // Test 3: bad stop bit, long break, then a good frame.
    fe0 = frame_err_cycles;
    br0 = busy_rises;
    vr0 = valid_rises;
    applyStimulus(8'hA3, 1'b0);
    repeat (100) @(negedge sysclk);
    checkOutput("t3_busy_in_break", busy, 1);
    uart_rx = 1'b1;
    repeat (20) @(negedge sysclk);
    checkOutput("t3_frame_err_once", frame_err_cycles - fe0, 1);
    checkOutput("t3_single_start",   busy_rises - br0, 1);
    checkOutput("t3_no_delivery",    valid_rises - vr0, 0);
    checkOutput("t3_idle_after",     busy, 0);
    applyStimulus(8'h3C, 1'b1);
    checkOutput("t3_rx_data",  rx_data,  8'h3C);
    checkOutput("t3_rx_valid", rx_valid, 1);
    checkOutput("t3_no_new_frame_err", frame_err_cycles - fe0, 1);
    pulseAck();
    repeat (8) @(negedge sysclk);

    // Test 4: two frames back to back without ack -> overrun.
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b1);
    checkOutput("t4_rx_data",  rx_data,  8'h12);
    checkOutput("t4_rx_valid", rx_valid, 1);
    checkOutput("t4_overrun",  overrun,  1);
    pulseAck();
    checkOutput("t4_ack_valid",   rx_valid, 0);
    checkOutput("t4_ack_overrun", overrun,  0);
    repeat (8) @(negedge sysclk);

    // Test 5: reset in the middle of data bit 4 of 0x81.
    vr0 = valid_rises;
    uart_rx = 1'b0;
    repeat (CLKS_PER_BIT) @(negedge sysclk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (CLKS_PER_BIT) @(negedge sysclk);
    end
    uart_rx = 1'b0;
    repeat (CLKS_PER_BIT / 2) @(negedge sysclk);
    checkOutput("t5_busy_before_reset", busy, 1);
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    checkOutput("t5_rx_data",   rx_data,   8'h00);
    checkOutput("t5_rx_valid",  rx_valid,  0);
    checkOutput("t5_overrun",   overrun,   0);
    checkOutput("t5_frame_err", frame_err, 0);
    checkOutput("t5_busy",      busy,      0);
    repeat (40) @(negedge sysclk);
    checkOutput("t5_no_delivery", valid_rises - vr0, 0);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("t5_next_rx_data",  rx_data,  8'hFF);
    checkOutput("t5_next_rx_valid", rx_valid, 1);
    pulseAck();
    repeat (8) @(negedge sysclk);

    // Test 6: ack lands in the delivery cycle of the second byte.
    applyStimulus(8'h12, 1'b1);
    checkOutput("t6_first_valid", rx_valid, 1);
    checkOutput("t6_first_data",  rx_data,  8'h12);
    fork
      applyStimulus(8'h34, 1'b1);
      begin
        repeat (PIN_TO_VALID - 1) @(posedge sysclk);
        @(negedge sysclk);
        pulseAck();
      end
    join
    checkOutput("t6_rx_data",  rx_data,  8'h34);
    checkOutput("t6_rx_valid", rx_valid, 1);
    checkOutput("t6_overrun",  overrun,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
